// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM block family.
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } breath_state_t;

  // All-ones value of an n-bit duty word; use as localparam DUTY_MAX = N'(duty_max(N)).
  function automatic int unsigned duty_max(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides clk down to a one-cycle step strobe every prescale+1 cycles.
module step_prescaler #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [PW-1:0] prescale,
  output logic          step
);

  logic [PW-1:0] pc;

  // The >= compare lets a live prescale decrease below pc wrap immediately.
  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      pc   <= '0;
      step <= 1'b0;
    end else if (pc >= prescale) begin
      pc   <= '0;
      step <= 1'b1;
    end else begin
      pc   <= pc + PW'(1);
      step <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_breath_sequencer.sv
// Triangle-ramped duty generator: fade up, hold, fade down, hold, repeat,
// with duty updates aligned to downstream PWM period boundaries.
module pwm_breath_sequencer
  import pwm_pkg::*;
#(
  parameter int N  = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [PW-1:0] prescale,
  input  logic [N-1:0]  inc,
  input  logic [7:0]    hold_periods,
  output logic          step,
  output logic [N-1:0]  duty,
  output logic          period_tick,
  output logic [2:0]    state
);

  localparam logic [N-1:0] DUTY_MAX = N'(duty_max(N));

  breath_state_t fsm, fsm_next;
  logic [N-1:0]  pcnt;
  logic [7:0]    hcnt, hcnt_next;
  logic [N-1:0]  duty_next;
  logic [N-1:0]  inc_eff;
  logic [N:0]    sum;
  logic [N-1:0]  up_val, down_val;
  logic          period_end;

  step_prescaler #(.PW(PW)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .prescale (prescale),
    .step     (step)
  );

  assign period_end = step & (pcnt == DUTY_MAX);
  assign state      = fsm;

  // Saturating ramp arithmetic; the sum carries one spare bit to catch overflow.
  always_comb begin
    inc_eff  = (inc == '0) ? N'(1) : inc;
    sum      = {1'b0, duty} + {1'b0, inc_eff};
    up_val   = sum[N] ? DUTY_MAX : sum[N-1:0];
    down_val = (duty <= inc_eff) ? '0 : duty - inc_eff;
  end

  always_comb begin
    fsm_next  = fsm;
    duty_next = duty;
    hcnt_next = hcnt;
    case (fsm)
      IDLE: begin
        fsm_next  = UP;
        duty_next = '0;
        hcnt_next = '0;
      end
      UP: if (period_end) begin
        duty_next = up_val;
        if (up_val == DUTY_MAX) begin
          fsm_next  = HOLD_HI;
          hcnt_next = '0;
        end
      end
      HOLD_HI: if (period_end) begin
        if (hcnt == hold_periods) begin
          fsm_next  = DOWN;
          hcnt_next = '0;
        end else begin
          hcnt_next = hcnt + 8'd1;
        end
      end
      DOWN: if (period_end) begin
        duty_next = down_val;
        if (down_val == '0) begin
          fsm_next  = HOLD_LO;
          hcnt_next = '0;
        end
      end
      HOLD_LO: if (period_end) begin
        if (hcnt == hold_periods) begin
          fsm_next  = UP;
          hcnt_next = '0;
        end else begin
          hcnt_next = hcnt + 8'd1;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  // Dropping ena clears everything so a re-enable always restarts the fade from zero.
  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      fsm         <= IDLE;
      duty        <= '0;
      hcnt        <= '0;
      pcnt        <= '0;
      period_tick <= 1'b0;
    end else begin
      fsm         <= fsm_next;
      duty        <= duty_next;
      hcnt        <= hcnt_next;
      period_tick <= period_end;
      if (step)
        pcnt <= pcnt + N'(1);
    end
  end

endmodule
